// File: rtl/wb_stage.sv
// wb_stage: writeback stage directly downstream of the memory stage.
// Holds the pipeline while a Dcache load or store is outstanding. Results go
// to the register file through a registered write port, and a watchdog flags
// a Dcache access that never completes.
// Optional feature: define WB_FORWARD_EN to add the fwd_valid/fwd_rd/fwd_data
// bypass outputs for the execute stage.
module wb_stage #(
    parameter int XLEN           = 64,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      is_bubble,
    input  logic                      in_is_load,
    input  logic                      in_is_store,
    input  logic                      in_rd_we,
    input  logic [REG_ADDR_WIDTH-1:0] in_rd,
    input  logic [XLEN-1:0]           ex_data,
    input  logic [XLEN-1:0]           mem_ex_rdata,
    input  logic                      dcache_valid,
    input  logic                      write_done,
    output logic                      stall,
    output logic                      wb_en,
    output logic [REG_ADDR_WIDTH-1:0] wb_rd,
    output logic [XLEN-1:0]           wb_data,
    output logic                      retire,
    output logic                      wb_timeout_err
`ifdef WB_FORWARD_EN
    ,
    output logic                      fwd_valid,
    output logic [REG_ADDR_WIDTH-1:0] fwd_rd,
    output logic [XLEN-1:0]           fwd_data
`endif
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_LOAD  = 2'd1,
        WAIT_STORE = 2'd2
    } state_t;

    state_t                    state_q, state_d;
    logic                      wb_en_q, wb_en_d;
    logic [REG_ADDR_WIDTH-1:0] wb_rd_q, wb_rd_d;
    logic [XLEN-1:0]           wb_data_q, wb_data_d;
    logic                      retire_q, retire_d;
    logic                      err_q, err_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [REG_ADDR_WIDTH-1:0] rd_lat_q, rd_lat_d;
    logic                      we_lat_q, we_lat_d;

    logic valid_in;
    logic is_store;
    logic is_load;
    logic in_wr;

    // A load+store combination is treated as a store; x0 writes are dropped.
    always_comb begin
        valid_in = !is_bubble;
        is_store = in_is_store;
        is_load  = in_is_load && !in_is_store;
        in_wr    = in_rd_we && (in_rd != '0);
    end

    // Next-state, writeback and watchdog logic; stall is combinational.
    always_comb begin
        state_d   = state_q;
        wb_en_d   = 1'b0;
        retire_d  = 1'b0;
        wb_rd_d   = wb_rd_q;
        wb_data_d = wb_data_q;
        err_d     = err_q;
        cnt_d     = cnt_q;
        rd_lat_d  = rd_lat_q;
        we_lat_d  = we_lat_q;
        stall     = 1'b0;

        case (state_q)
            IDLE: begin
                if (valid_in) begin
                    if (is_store) begin
                        if (write_done) begin
                            retire_d = 1'b1;
                        end else begin
                            state_d = WAIT_STORE;
                            cnt_d   = '0;
                            stall   = 1'b1;
                        end
                    end else if (is_load) begin
                        if (dcache_valid) begin
                            retire_d = 1'b1;
                            wb_en_d  = in_wr;
                            if (in_wr) begin
                                wb_rd_d   = in_rd;
                                wb_data_d = mem_ex_rdata;
                            end
                        end else begin
                            state_d  = WAIT_LOAD;
                            cnt_d    = '0;
                            rd_lat_d = in_rd;
                            we_lat_d = in_wr;
                            stall    = 1'b1;
                        end
                    end else begin
                        retire_d = 1'b1;
                        wb_en_d  = in_wr;
                        if (in_wr) begin
                            wb_rd_d   = in_rd;
                            wb_data_d = ex_data;
                        end
                    end
                end
            end
            WAIT_LOAD, WAIT_STORE: begin
                // Watchdog saturates at its last value; the error is sticky.
                if (cnt_q == CNT_LAST) begin
                    err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                if (state_q == WAIT_LOAD) begin
                    stall = !dcache_valid;
                    if (dcache_valid) begin
                        state_d  = IDLE;
                        retire_d = 1'b1;
                        wb_en_d  = we_lat_q;
                        if (we_lat_q) begin
                            wb_rd_d   = rd_lat_q;
                            wb_data_d = mem_ex_rdata;
                        end
                    end
                end else begin
                    stall = !write_done;
                    if (write_done) begin
                        state_d  = IDLE;
                        retire_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs; reset abandons any outstanding access.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            wb_en_q   <= 1'b0;
            wb_rd_q   <= '0;
            wb_data_q <= '0;
            retire_q  <= 1'b0;
            err_q     <= 1'b0;
            cnt_q     <= '0;
            rd_lat_q  <= '0;
            we_lat_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            wb_en_q   <= wb_en_d;
            wb_rd_q   <= wb_rd_d;
            wb_data_q <= wb_data_d;
            retire_q  <= retire_d;
            err_q     <= err_d;
            cnt_q     <= cnt_d;
            rd_lat_q  <= rd_lat_d;
            we_lat_q  <= we_lat_d;
        end
    end

    assign wb_en          = wb_en_q;
    assign wb_rd          = wb_rd_q;
    assign wb_data        = wb_data_q;
    assign retire         = retire_q;
    assign wb_timeout_err = err_q;

`ifdef WB_FORWARD_EN
    // Bypass taps mirror the register-file write port in the same cycle.
    assign fwd_valid = wb_en_q;
    assign fwd_rd    = wb_rd_q;
    assign fwd_data  = wb_data_q;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Directed self-checking bench for wb_stage (TIMEOUT_CYCLES = 8).
module tb_wb_stage;

    localparam int XLEN = 64;
    localparam int RW   = 5;

    logic            clk = 1'b0;
    logic            reset;
    logic            is_bubble;
    logic            in_is_load;
    logic            in_is_store;
    logic            in_rd_we;
    logic [RW-1:0]   in_rd;
    logic [XLEN-1:0] ex_data;
    logic [XLEN-1:0] mem_ex_rdata;
    logic            dcache_valid;
    logic            write_done;
    logic            stall;
    logic            wb_en;
    logic [RW-1:0]   wb_rd;
    logic [XLEN-1:0] wb_data;
    logic            retire;
    logic            wb_timeout_err;
`ifdef WB_FORWARD_EN
    logic            fwd_valid;
    logic [RW-1:0]   fwd_rd;
    logic [XLEN-1:0] fwd_data;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    wb_stage #(.XLEN(XLEN), .REG_ADDR_WIDTH(RW), .TIMEOUT_CYCLES(8)) dut (
        .clk            (clk),
        .reset          (reset),
        .is_bubble      (is_bubble),
        .in_is_load     (in_is_load),
        .in_is_store    (in_is_store),
        .in_rd_we       (in_rd_we),
        .in_rd          (in_rd),
        .ex_data        (ex_data),
        .mem_ex_rdata   (mem_ex_rdata),
        .dcache_valid   (dcache_valid),
        .write_done     (write_done),
        .stall          (stall),
        .wb_en          (wb_en),
        .wb_rd          (wb_rd),
        .wb_data        (wb_data),
        .retire         (retire),
        .wb_timeout_err (wb_timeout_err)
`ifdef WB_FORWARD_EN
        ,
        .fwd_valid      (fwd_valid),
        .fwd_rd         (fwd_rd),
        .fwd_data       (fwd_data)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        is_bubble    = 1'b1;
        in_is_load   = 1'b0;
        in_is_store  = 1'b0;
        in_rd_we     = 1'b0;
        in_rd        = '0;
        ex_data      = '0;
        mem_ex_rdata = '0;
        dcache_valid = 1'b0;
        write_done   = 1'b0;
    endtask

    task automatic drive_op(input logic ld, input logic st, input logic we,
                            input logic [RW-1:0] rd, input logic [XLEN-1:0] ex);
        is_bubble   = 1'b0;
        in_is_load  = ld;
        in_is_store = st;
        in_rd_we    = we;
        in_rd       = rd;
        ex_data     = ex;
    endtask

    task automatic test_reset();
        checks++; if ({wb_en, retire, wb_timeout_err, stall} !== 4'b0) begin failures++; $display("FAIL por_outputs: got %b expected 0000", {wb_en, retire, wb_timeout_err, stall}); end
        checks++; if (wb_rd !== '0 || wb_data !== '0) begin failures++; $display("FAIL por_rd_data: got rd=%0d data=%0h expected 0/0", wb_rd, wb_data); end
        reset = 1'b1;
        tick();
        drive_op(1'b1, 1'b0, 1'b1, 5'd3, '0);
        #1;
        checks++; if (stall !== 1'b1) begin failures++; $display("FAIL rst_load_accept_stall: got %b expected 1", stall); end
        tick();
        drive_idle();
        tick();
        #2 reset = 1'b0;
        #1;
        checks++; if ({wb_en, retire, wb_timeout_err, stall} !== 4'b0) begin failures++; $display("FAIL mid_wait_reset_outputs: got %b expected 0000", {wb_en, retire, wb_timeout_err, stall}); end
        reset = 1'b1;
        tick();
        dcache_valid = 1'b1;
        mem_ex_rdata = 64'hDEAD;
        #1;
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL rst_idle_stall: got %b expected 0", stall); end
        tick();
        checks++; if (wb_en !== 1'b0 || retire !== 1'b0) begin failures++; $display("FAIL rst_spurious_valid: got wb_en=%b retire=%b expected 0/0", wb_en, retire); end
        drive_idle();
        tick();
    endtask

    task automatic test_alu();
        drive_op(1'b0, 1'b0, 1'b1, 5'd5, 64'h1234);
        #1;
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL alu_stall: got %b expected 0", stall); end
        tick();
        drive_idle();
        checks++; if (wb_en !== 1'b1 || retire !== 1'b1) begin failures++; $display("FAIL alu_wb_en_retire: got %b/%b expected 1/1", wb_en, retire); end
        checks++; if (wb_rd !== 5'd5 || wb_data !== 64'h1234) begin failures++; $display("FAIL alu_rd_data: got rd=%0d data=%0h expected 5/1234", wb_rd, wb_data); end
        tick();
        checks++; if (wb_en !== 1'b0 || retire !== 1'b0) begin failures++; $display("FAIL alu_one_cycle: got %b/%b expected 0/0", wb_en, retire); end
        checks++; if (wb_rd !== 5'd5 || wb_data !== 64'h1234) begin failures++; $display("FAIL alu_hold: got rd=%0d data=%0h expected 5/1234", wb_rd, wb_data); end
    endtask

    task automatic test_load_miss();
        drive_op(1'b1, 1'b0, 1'b1, 5'd10, '0);
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (stall !== 1'b1 || retire !== 1'b0) begin failures++; $display("FAIL load_wait_%0d: got stall=%b retire=%b expected 1/0", i, stall, retire); end
            tick();
        end
        dcache_valid = 1'b1;
        mem_ex_rdata = 64'hFFFFFFFFFFFFFF80;
        #1;
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL load_valid_stall: got %b expected 0", stall); end
        tick();
        drive_idle();
        checks++; if (wb_en !== 1'b1 || retire !== 1'b1) begin failures++; $display("FAIL load_wb_en_retire: got %b/%b expected 1/1", wb_en, retire); end
        checks++; if (wb_rd !== 5'd10 || wb_data !== 64'hFFFFFFFFFFFFFF80) begin failures++; $display("FAIL load_rd_data: got rd=%0d data=%0h expected 10/ffffffffffffff80", wb_rd, wb_data); end
        tick();
        checks++; if (wb_en !== 1'b0 || retire !== 1'b0) begin failures++; $display("FAIL load_one_cycle: got %b/%b expected 0/0", wb_en, retire); end
    endtask

    task automatic test_back_to_back();
        drive_op(1'b1, 1'b0, 1'b1, 5'd7, '0);
        dcache_valid = 1'b1;
        mem_ex_rdata = 64'hA5A5A5A5A5A5A5A5;
        #1;
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL b2b_hit_stall: got %b expected 0", stall); end
        tick();
        dcache_valid = 1'b0;
        drive_op(1'b0, 1'b0, 1'b1, 5'd8, 64'h55);
        #1;
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL b2b_alu_stall: got %b expected 0", stall); end
        checks++; if (wb_en !== 1'b1 || retire !== 1'b1 || wb_rd !== 5'd7 || wb_data !== 64'hA5A5A5A5A5A5A5A5) begin failures++; $display("FAIL b2b_first: got en=%b ret=%b rd=%0d data=%0h expected 1/1/7/a5a5a5a5a5a5a5a5", wb_en, retire, wb_rd, wb_data); end
        tick();
        drive_idle();
        checks++; if (wb_en !== 1'b1 || retire !== 1'b1 || wb_rd !== 5'd8 || wb_data !== 64'h55) begin failures++; $display("FAIL b2b_second: got en=%b ret=%b rd=%0d data=%0h expected 1/1/8/55", wb_en, retire, wb_rd, wb_data); end
        tick();
    endtask

    task automatic test_store_x0();
        drive_op(1'b0, 1'b1, 1'b0, 5'd0, '0);
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++; if (stall !== 1'b1) begin failures++; $display("FAIL store_wait_%0d: got stall=%b expected 1", i, stall); end
            tick();
        end
        write_done = 1'b1;
        #1;
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL store_done_stall: got %b expected 0", stall); end
        tick();
        write_done = 1'b0;
        drive_op(1'b0, 1'b0, 1'b1, 5'd0, 64'h99);
        checks++; if (retire !== 1'b1 || wb_en !== 1'b0) begin failures++; $display("FAIL store_retire: got ret=%b en=%b expected 1/0", retire, wb_en); end
        checks++; if (wb_rd !== 5'd8 || wb_data !== 64'h55) begin failures++; $display("FAIL store_hold: got rd=%0d data=%0h expected 8/55", wb_rd, wb_data); end
        tick();
        drive_op(1'b1, 1'b1, 1'b1, 5'd4, '0);
        write_done = 1'b1;
        checks++; if (retire !== 1'b1 || wb_en !== 1'b0) begin failures++; $display("FAIL x0_retire: got ret=%b en=%b expected 1/0", retire, wb_en); end
        tick();
        drive_idle();
        checks++; if (retire !== 1'b1 || wb_en !== 1'b0) begin failures++; $display("FAIL ld_st_as_store: got ret=%b en=%b expected 1/0", retire, wb_en); end
        tick();
    endtask

    task automatic test_timeout();
        drive_op(1'b1, 1'b0, 1'b1, 5'd12, '0);
        tick();
        for (int i = 1; i <= 7; i++) begin
            tick();
            checks++; if (wb_timeout_err !== 1'b0) begin failures++; $display("FAIL timeout_early_%0d: got %b expected 0", i, wb_timeout_err); end
        end
        tick();
        checks++; if (wb_timeout_err !== 1'b1) begin failures++; $display("FAIL timeout_rise: got %b expected 1", wb_timeout_err); end
        tick();
        tick();
        checks++; if (stall !== 1'b1 || wb_timeout_err !== 1'b1) begin failures++; $display("FAIL timeout_keep_wait: got stall=%b err=%b expected 1/1", stall, wb_timeout_err); end
        dcache_valid = 1'b1;
        mem_ex_rdata = 64'h77;
        tick();
        drive_idle();
        checks++; if (wb_en !== 1'b1 || retire !== 1'b1 || wb_rd !== 5'd12 || wb_data !== 64'h77) begin failures++; $display("FAIL timeout_complete: got en=%b ret=%b rd=%0d data=%0h expected 1/1/12/77", wb_en, retire, wb_rd, wb_data); end
        tick();
        checks++; if (wb_timeout_err !== 1'b1) begin failures++; $display("FAIL timeout_sticky: got %b expected 1", wb_timeout_err); end
        reset = 1'b0;
        #1;
        checks++; if (wb_timeout_err !== 1'b0) begin failures++; $display("FAIL timeout_reset_clear: got %b expected 0", wb_timeout_err); end
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0;
        drive_idle();
        #12;
        test_reset();
        test_alu();
        test_load_miss();
        test_back_to_back();
        test_store_x0();
        test_timeout();
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
